mac_lookup_req: RTL and testbench
=================================

Name: mac_lookup_req

Overview:
Ingress stage for the 10G Ethernet path. It sits directly upstream of mac_table. It accepts the 64-bit receive AXI-Stream, extracts the destination MAC from the first beat of each frame, and issues one tagged lookup request per frame. It forwards the frame downstream tagged with the same lookup ID, tracks outstanding lookups against a credit limit, and drops runt frames.

Parameters:
ID_W, 4, lookup ID width; must match the mac_table check_id width.
MAX_OUTSTANDING, 16, maximum unanswered lookups; must be <= 2**ID_W.
CNT_W, 16, width of the runt-drop counter.

Ports:
i_clk  in  1  single clock domain
i_rst  in  1  asynchronous, active-low reset
s_axis_rx_data  in  64  receive data; byte0 in [7:0]
s_axis_rx_keep  in  8  byte enables, contiguous from bit 0
s_axis_rx_valid  in  1  receive valid
s_axis_rx_last  in  1  end of frame
s_axis_rx_ready  out  1  receive ready
m_axis_tx_data  out  64  forwarded data
m_axis_tx_keep  out  8  forwarded keep
m_axis_tx_valid  out  1  forwarded valid
m_axis_tx_last  out  1  forwarded last
m_axis_tx_user  out  ID_W  lookup ID of the frame, held for every beat
m_axis_tx_ready  in  1  downstream ready
o_check_mac  out  48  destination MAC to mac_table
o_check_id  out  ID_W  lookup ID
o_check_valid  out  1  one-cycle request pulse
i_result_valid  in  1  mac_table result strobe; returns one credit
i_result_id  in  ID_W  returned ID; informational only, not checked
o_outstanding  out  ID_W+1  current count of unanswered lookups
o_runt_cnt  out  CNT_W  number of dropped runt frames
o_credit_err  out  1  sticky flag: result received with zero outstanding

Behaviour:
- Reset (i_rst low, asynchronous): all outputs 0; in_frame=0, drop=0, id counter=0, outstanding=0.
- Beat transfer occurs when s_axis_rx_valid && s_axis_rx_ready.
- SOF is a transfer while in_frame=0. in_frame is set on any non-last transfer and cleared on a last transfer.
- Stall: s_axis_rx_ready = (!m_axis_tx_valid || m_axis_tx_ready) && !(in_frame==0 && outstanding==MAX_OUTSTANDING).
  - Stalling applies only at frame boundaries; a frame already in progress is never stalled for credit.
- Runt: an SOF beat with keep[5:0] != 6'h3F.
  - The whole frame is consumed (ready follows the normal rule) but not forwarded, and no lookup is issued.
  - If the runt beat is not last, the drop flag stays set until the last beat.
  - o_runt_cnt increments once per runt frame and saturates at all-ones.
- Good SOF, registered with 1-cycle latency:
  - o_check_valid=1 for exactly one cycle.
  - o_check_mac = {d[7:0],d[15:8],d[23:16],d[31:24],d[39:32],d[47:40]}, i.e. first wire byte in the MSBs.
  - o_check_id = id counter.
  - The id counter then increments, wrapping from 2**ID_W-1 to 0.
  - o_check_mac and o_check_id hold their values when o_check_valid=0.
- Forward path: a single register stage.
  - The first beat appears on m_axis in the same cycle as o_check_valid.
  - m_axis_tx_user carries the frame ID for all of its beats.
  - data, keep and last are held stable while valid && !ready.
- Outstanding count:
  - +1 on each issued lookup, -1 on each i_result_valid.
  - Both in the same cycle leaves it unchanged.
  - i_result_valid with outstanding==0 (and no issue that cycle) leaves it at 0 and sets o_credit_err, which is cleared only by reset.
- Back-to-back: the SOF of the next frame is accepted in the cycle after the previous last beat, with no bubble required.

Decomposition:
- Shared package ten_eth_pkg holds:
  - MAC_W=48, AXIS_DATA_W=64, AXIS_KEEP_W=8, LOOKUP_ID_W=4;
  - the runt keep mask constant 6'h3F;
  - a function for MAC byte-swap (wire order to 48-bit MAC).
- One sub-module, lookup_credit_ctr, holds the outstanding counter, the saturation/error logic and the stall output.
- Everything else stays in mac_lookup_req.

Test Plan:
1. Single 64-byte frame, dst 00:11:22:33:44:55, m_ready=1 -> one o_check_valid pulse with o_check_mac=48'h001122334455 and id 0; 8 beats out with user=0; o_outstanding=1.
2. 17 frames sent with no i_result_valid -> ids 0..15 issued; the 17th SOF sees s_axis_rx_ready=0 and o_outstanding=16. One i_result_valid -> the 17th frame is accepted with id 0.
3. Runt: a single beat with keep=8'h1F and last=1 -> nothing on m_axis, no o_check_valid, o_runt_cnt=1. The next good frame gets the id that was expected before the runt.
4. m_axis_tx_ready toggled 1/0 every cycle during a 3-frame burst -> no beat lost or duplicated, data stable while stalled, exactly 3 lookups issued.
5. i_result_valid in the same cycle as an issued lookup with outstanding=5 -> count stays 5. i_result_valid with outstanding=0 -> count stays 0 and o_credit_err=1.
6. i_rst asserted mid-frame (beat 3 of 8) -> all outputs 0 immediately. After release, a fresh frame is handled from id 0 and the residual beats of the old frame are not forwarded as SOF; the bench does not resend them.

Source files
------------

// File: rtl/ten_eth_pkg.sv
// Shared constants and helpers for the 10G Ethernet ingress path.
package ten_eth_pkg;

  localparam int MAC_W       = 48;
  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;
  localparam int LOOKUP_ID_W = 4;

  // A first beat must carry at least the six destination MAC bytes.
  localparam logic [5:0] RUNT_KEEP_MASK = 6'h3F;

  // First wire byte (data[7:0]) becomes the MSB of the MAC.
  function automatic logic [MAC_W-1:0] mac_from_wire(input logic [AXIS_DATA_W-1:0] d);
    logic [MAC_W-1:0] m;
    m = '0;
    for (int i = 0; i < 6; i++) begin
      m[MAC_W-1-8*i -: 8] = d[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/lookup_credit_ctr.sv
// Outstanding-lookup credit counter with underflow error flag and frame-boundary stall.
module lookup_credit_ctr
  import ten_eth_pkg::*;
#(
  parameter int ID_W            = LOOKUP_ID_W,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_issue,
  input  logic          i_return,
  input  logic          i_in_frame,
  output logic [ID_W:0] o_outstanding,
  output logic          o_credit_err,
  output logic          o_stall
);

  localparam logic [ID_W:0] MAX_CNT = MAX_OUTSTANDING[ID_W:0];
  localparam logic [ID_W:0] CNT_ONE = {{ID_W{1'b0}}, 1'b1};

  logic [ID_W:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({i_issue, i_return})
      2'b10: cnt_d = cnt_q + CNT_ONE;
      2'b01: begin
        // A result with nothing outstanding is a protocol error; the count stays at zero.
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Only a new frame waits for credit; a frame already started always completes.
  assign o_stall       = !i_in_frame && (cnt_q == MAX_CNT);
  assign o_outstanding = cnt_q;
  assign o_credit_err  = err_q;

endmodule

// File: rtl/mac_lookup_req.sv
// Ingress stage: issues one tagged MAC lookup per frame, forwards the frame with its ID,
// and drops runt frames.
module mac_lookup_req
  import ten_eth_pkg::*;
#(
  parameter int ID_W            = LOOKUP_ID_W,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_W           = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [AXIS_DATA_W-1:0] s_axis_rx_data,
  input  logic [AXIS_KEEP_W-1:0] s_axis_rx_keep,
  input  logic                   s_axis_rx_valid,
  input  logic                   s_axis_rx_last,
  output logic                   s_axis_rx_ready,
  output logic [AXIS_DATA_W-1:0] m_axis_tx_data,
  output logic [AXIS_KEEP_W-1:0] m_axis_tx_keep,
  output logic                   m_axis_tx_valid,
  output logic                   m_axis_tx_last,
  output logic [ID_W-1:0]        m_axis_tx_user,
  input  logic                   m_axis_tx_ready,
  output logic [MAC_W-1:0]       o_check_mac,
  output logic [ID_W-1:0]        o_check_id,
  output logic                   o_check_valid,
  input  logic                   i_result_valid,
  input  logic [ID_W-1:0]        i_result_id,
  output logic [ID_W:0]          o_outstanding,
  output logic [CNT_W-1:0]       o_runt_cnt,
  output logic                   o_credit_err
);

  localparam logic [ID_W-1:0]  ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic accept, sof, runt, good_sof, fwd, stall;

  logic                   in_frame_q, in_frame_d;
  logic                   drop_q, drop_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [ID_W-1:0]        frame_id_q, frame_id_d;
  logic [AXIS_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [AXIS_KEEP_W-1:0] tx_keep_q, tx_keep_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   tx_last_q, tx_last_d;
  logic [ID_W-1:0]        tx_user_q, tx_user_d;
  logic                   check_valid_q, check_valid_d;
  logic [MAC_W-1:0]       check_mac_q, check_mac_d;
  logic [ID_W-1:0]        check_id_q, check_id_d;
  logic [CNT_W-1:0]       runt_cnt_q, runt_cnt_d;

  // Result IDs are not cross-checked against issued IDs.
  logic unused_result_id;
  assign unused_result_id = ^i_result_id;

  lookup_credit_ctr #(
    .ID_W            (ID_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue       (good_sof),
    .i_return      (i_result_valid),
    .i_in_frame    (in_frame_q),
    .o_outstanding (o_outstanding),
    .o_credit_err  (o_credit_err),
    .o_stall       (stall)
  );

  // Ready is forced low while reset is held so every output reads zero.
  assign s_axis_rx_ready = i_rst && (!tx_valid_q || m_axis_tx_ready) && !stall;

  always_comb begin
    accept   = s_axis_rx_valid && s_axis_rx_ready;
    sof      = accept && !in_frame_q;
    runt     = sof && ((s_axis_rx_keep[5:0] & RUNT_KEEP_MASK) != RUNT_KEEP_MASK);
    good_sof = sof && !runt;
    fwd      = good_sof || (accept && in_frame_q && !drop_q);

    in_frame_d    = accept ? !s_axis_rx_last : in_frame_q;
    drop_d        = drop_q;
    id_d          = id_q;
    frame_id_d    = frame_id_q;
    tx_data_d     = tx_data_q;
    tx_keep_d     = tx_keep_q;
    tx_valid_d    = tx_valid_q;
    tx_last_d     = tx_last_q;
    tx_user_d     = tx_user_q;
    check_valid_d = good_sof;
    check_mac_d   = check_mac_q;
    check_id_d    = check_id_q;
    runt_cnt_d    = runt_cnt_q;

    if (sof)                         drop_d = runt && !s_axis_rx_last;
    else if (accept && s_axis_rx_last) drop_d = 1'b0;

    if (good_sof) begin
      id_d        = id_q + ID_ONE;
      frame_id_d  = id_q;
      check_mac_d = mac_from_wire(s_axis_rx_data);
      check_id_d  = id_q;
    end

    if (runt && (runt_cnt_q != '1)) runt_cnt_d = runt_cnt_q + CNT_ONE;

    // Single output register: load on a forwarded beat, otherwise drain on ready.
    if (fwd) begin
      tx_data_d  = s_axis_rx_data;
      tx_keep_d  = s_axis_rx_keep;
      tx_last_d  = s_axis_rx_last;
      tx_valid_d = 1'b1;
      tx_user_d  = good_sof ? id_q : frame_id_q;
    end else if (m_axis_tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_frame_q    <= 1'b0;
      drop_q        <= 1'b0;
      id_q          <= '0;
      frame_id_q    <= '0;
      tx_data_q     <= '0;
      tx_keep_q     <= '0;
      tx_valid_q    <= 1'b0;
      tx_last_q     <= 1'b0;
      tx_user_q     <= '0;
      check_valid_q <= 1'b0;
      check_mac_q   <= '0;
      check_id_q    <= '0;
      runt_cnt_q    <= '0;
    end else begin
      in_frame_q    <= in_frame_d;
      drop_q        <= drop_d;
      id_q          <= id_d;
      frame_id_q    <= frame_id_d;
      tx_data_q     <= tx_data_d;
      tx_keep_q     <= tx_keep_d;
      tx_valid_q    <= tx_valid_d;
      tx_last_q     <= tx_last_d;
      tx_user_q     <= tx_user_d;
      check_valid_q <= check_valid_d;
      check_mac_q   <= check_mac_d;
      check_id_q    <= check_id_d;
      runt_cnt_q    <= runt_cnt_d;
    end
  end

  assign m_axis_tx_data  = tx_data_q;
  assign m_axis_tx_keep  = tx_keep_q;
  assign m_axis_tx_valid = tx_valid_q;
  assign m_axis_tx_last  = tx_last_q;
  assign m_axis_tx_user  = tx_user_q;
  assign o_check_valid   = check_valid_q;
  assign o_check_mac     = check_mac_q;
  assign o_check_id      = check_id_q;
  assign o_runt_cnt      = runt_cnt_q;

endmodule

// File: tb/tb_mac_lookup_req.sv
// Directed testbench for mac_lookup_req: lookups, forwarding, credits, runts and reset.
module tb_mac_lookup_req;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [3:0]  u;
  } beat_t;

  logic        i_clk;
  logic        i_rst;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_valid, s_last, s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_valid, m_last, m_ready;
  logic [3:0]  m_user;
  logic [47:0] check_mac;
  logic [3:0]  check_id;
  logic        check_valid;
  logic        rv;
  logic [3:0]  rid;
  logic [4:0]  outstanding;
  logic [15:0] runt_cnt;
  logic        credit_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_viol = 0;
  bit toggle_en = 0;
  logic [3:0] exp_id;

  beat_t       obs_beats[$], exp_beats[$];
  logic [51:0] obs_lk[$], exp_lk[$];
  bit          prev_stall = 0;
  beat_t       prev_beat;

  mac_lookup_req dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .s_axis_rx_data  (s_data),
    .s_axis_rx_keep  (s_keep),
    .s_axis_rx_valid (s_valid),
    .s_axis_rx_last  (s_last),
    .s_axis_rx_ready (s_ready),
    .m_axis_tx_data  (m_data),
    .m_axis_tx_keep  (m_keep),
    .m_axis_tx_valid (m_valid),
    .m_axis_tx_last  (m_last),
    .m_axis_tx_user  (m_user),
    .m_axis_tx_ready (m_ready),
    .o_check_mac     (check_mac),
    .o_check_id      (check_id),
    .o_check_valid   (check_valid),
    .i_result_valid  (rv),
    .i_result_id     (rid),
    .o_outstanding   (outstanding),
    .o_runt_cnt      (runt_cnt),
    .o_credit_err    (credit_err)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  always @(posedge i_clk) begin
    if (toggle_en) begin
      #1;
      m_ready = ~m_ready;
    end
  end

  // Outputs are stable at the falling edge.
  always @(negedge i_clk) begin
    beat_t cur;
    cur = {m_data, m_keep, m_last, m_user};
    if (m_valid && m_ready) obs_beats.push_back(cur);
    if (check_valid) obs_lk.push_back({check_mac, check_id});
    if (prev_stall && (!m_valid || cur !== prev_beat)) stall_viol++;
    prev_stall = m_valid && !m_ready;
    prev_beat  = cur;
  end

  function automatic logic [63:0] beat_data(input logic [47:0] mac, input logic [7:0] tag, input int i);
    logic [63:0] d;
    d = '0;
    if (i == 0) begin
      d[63:48] = {8'hA5, tag};
      for (int b = 0; b < 6; b++) d[8*b +: 8] = mac[47-8*b -: 8];
    end else begin
      d = {tag, 48'h0123_4567_89AB, 8'(i)};
    end
    return d;
  endfunction

  task automatic drain(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_q();
    obs_beats.delete(); exp_beats.delete();
    obs_lk.delete();    exp_lk.delete();
  endtask

  task automatic apply_reset();
    @(posedge i_clk); #1;
    i_rst = 0; s_valid = 0; rv = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat transfers.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, output bit ok);
    s_data = d; s_keep = k; s_last = l; s_valid = 1; ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge i_clk);
      if (s_ready) ok = 1;
      @(posedge i_clk); #1;
    end
    s_valid = 0;
  endtask

  task automatic send_frame(input logic [47:0] mac, input logic [7:0] tag, input int nbeats, input bit runt);
    bit ok;
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.d = beat_data(mac, tag, i);
      b.k = (i == 0 && runt) ? 8'h1F : 8'hFF;
      b.l = (i == nbeats - 1);
      b.u = exp_id;
      if (!runt) exp_beats.push_back(b);
      drive_beat(b.d, b.k, b.l, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL send_timeout tag %h beat %0d: ready never seen, required within 100 cycles", tag, i);
      end
    end
    if (!runt) begin
      exp_lk.push_back({mac, exp_id});
      exp_id++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({s_ready, m_valid, m_data, m_keep, m_last, m_user, check_valid, check_mac, check_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b mv=%b md=%h cv=%b cm=%h want all 0", s_ready, m_valid, m_data, check_valid, check_mac);
    end
    checks++;
    if ({outstanding, runt_cnt, credit_err} !== '0) begin
      errors++;
      $display("FAIL reset_status got out=%0d runt=%0d err=%b want 0", outstanding, runt_cnt, credit_err);
    end
    i_rst = 1;
  endtask

  task automatic test_single();
    clear_q(); exp_id = 0;
    send_frame(48'h001122334455, 8'h01, 8, 0);
    drain(4);
    checks++;
    if (outstanding !== 5'd1) begin errors++; $display("FAIL single_outstanding got %0d want 1", outstanding); end
    checks++;
    if (obs_lk.size() != 1 || obs_lk[0] !== {48'h001122334455, 4'd0}) begin
      errors++; $display("FAIL single_lookup got %0d lookups first %h want 1 of %h", obs_lk.size(), obs_lk[0], {48'h001122334455, 4'd0});
    end
    checks++;
    if (obs_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL single_beat_count got %0d want %0d", obs_beats.size(), exp_beats.size());
    end else foreach (exp_beats[i]) begin
      checks++;
      if (obs_beats[i] !== exp_beats[i]) begin errors++; $display("FAIL single_beat[%0d] got %h want %h", i, obs_beats[i], exp_beats[i]); end
    end
  endtask

  task automatic test_credit();
    int t0;
    apply_reset();
    clear_q(); exp_id = 0;
    t0 = cyc;
    for (int f = 0; f < 16; f++) send_frame(48'h02AA_0000_0000 + 48'(f), 8'(8'h10 + f), 1, 0);
    checks++;
    if (cyc - t0 != 16) begin errors++; $display("FAIL b2b_cycles got %0d want 16", cyc - t0); end
    drain(3);
    checks++;
    if (outstanding !== 5'd16) begin errors++; $display("FAIL credit_full got %0d want 16", outstanding); end
    s_data = beat_data(48'h02BB_0000_0011, 8'h20, 0); s_keep = 8'hFF; s_last = 1; s_valid = 1;
    repeat (3) @(negedge i_clk);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL credit_stall ready got %b want 0", s_ready); end
    @(posedge i_clk); #1 rv = 1;
    @(posedge i_clk); #1 rv = 0;
    send_frame(48'h02BB_0000_0011, 8'h20, 1, 0);
    drain(3);
    checks++;
    if (outstanding !== 5'd16) begin errors++; $display("FAIL credit_refill got %0d want 16", outstanding); end
    checks++;
    if (obs_lk.size() != exp_lk.size()) begin
      errors++; $display("FAIL credit_lookup_count got %0d want %0d", obs_lk.size(), exp_lk.size());
    end else foreach (exp_lk[i]) begin
      checks++;
      if (obs_lk[i] !== exp_lk[i]) begin errors++; $display("FAIL credit_lookup[%0d] got %h want %h", i, obs_lk[i], exp_lk[i]); end
    end
    checks++;
    if (obs_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL credit_beat_count got %0d want %0d", obs_beats.size(), exp_beats.size());
    end else foreach (exp_beats[i]) begin
      checks++;
      if (obs_beats[i] !== exp_beats[i]) begin errors++; $display("FAIL credit_beat[%0d] got %h want %h", i, obs_beats[i], exp_beats[i]); end
    end
  endtask

  task automatic test_runt();
    @(posedge i_clk); #1 rv = 1;
    repeat (16) @(posedge i_clk);
    #1 rv = 0;
    clear_q();
    checks++;
    if (outstanding !== 5'd0) begin errors++; $display("FAIL runt_pre_outstanding got %0d want 0", outstanding); end
    send_frame(48'h0300_0000_0001, 8'h30, 1, 1);
    drain(4);
    checks++;
    if (obs_beats.size() != 0 || obs_lk.size() != 0 || runt_cnt !== 16'd1) begin
      errors++; $display("FAIL runt_single got beats=%0d lookups=%0d runt=%0d want 0 0 1", obs_beats.size(), obs_lk.size(), runt_cnt);
    end
    send_frame(48'h0300_0000_0002, 8'h31, 2, 0);
    send_frame(48'h0300_0000_0003, 8'h32, 3, 1);
    send_frame(48'h0300_0000_0004, 8'h33, 2, 0);
    drain(4);
    checks++;
    if (runt_cnt !== 16'd2) begin errors++; $display("FAIL runt_count got %0d want 2", runt_cnt); end
    checks++;
    if (obs_lk.size() != 2 || obs_lk[0] !== {48'h0300_0000_0002, 4'd1} || obs_lk[1] !== {48'h0300_0000_0004, 4'd2}) begin
      errors++; $display("FAIL runt_lookups got %0d lookups first %h want ids 1 and 2", obs_lk.size(), obs_lk[0]);
    end
    checks++;
    if (obs_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL runt_beat_count got %0d want %0d", obs_beats.size(), exp_beats.size());
    end else foreach (exp_beats[i]) begin
      checks++;
      if (obs_beats[i] !== exp_beats[i]) begin errors++; $display("FAIL runt_beat[%0d] got %h want %h", i, obs_beats[i], exp_beats[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_q(); stall_viol = 0;
    toggle_en = 1;
    send_frame(48'h0400_0000_0001, 8'h40, 3, 0);
    send_frame(48'h0400_0000_0002, 8'h41, 3, 0);
    send_frame(48'h0400_0000_0003, 8'h42, 3, 0);
    drain(20);
    @(posedge i_clk); #2 toggle_en = 0;
    @(posedge i_clk); #1 m_ready = 1;
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes while stalled want 0", stall_viol); end
    checks++;
    if (obs_lk.size() != exp_lk.size()) begin
      errors++; $display("FAIL bp_lookup_count got %0d want %0d", obs_lk.size(), exp_lk.size());
    end else foreach (exp_lk[i]) begin
      checks++;
      if (obs_lk[i] !== exp_lk[i]) begin errors++; $display("FAIL bp_lookup[%0d] got %h want %h", i, obs_lk[i], exp_lk[i]); end
    end
    checks++;
    if (obs_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL bp_beat_count got %0d want %0d", obs_beats.size(), exp_beats.size());
    end else foreach (exp_beats[i]) begin
      checks++;
      if (obs_beats[i] !== exp_beats[i]) begin errors++; $display("FAIL bp_beat[%0d] got %h want %h", i, obs_beats[i], exp_beats[i]); end
    end
  endtask

  task automatic test_same_cycle();
    beat_t b;
    clear_q();
    checks++;
    if (outstanding !== 5'd5) begin errors++; $display("FAIL same_pre_outstanding got %0d want 5", outstanding); end
    b.d = beat_data(48'h0500_0000_0001, 8'h50, 0); b.k = 8'hFF; b.l = 1; b.u = exp_id;
    exp_beats.push_back(b);
    exp_lk.push_back({48'h0500_0000_0001, exp_id});
    exp_id++;
    s_data = b.d; s_keep = b.k; s_last = 1; s_valid = 1; rv = 1;
    @(negedge i_clk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b want 1", s_ready); end
    @(posedge i_clk); #1 s_valid = 0; rv = 0;
    drain(3);
    checks++;
    if (outstanding !== 5'd5) begin errors++; $display("FAIL same_cycle_outstanding got %0d want 5", outstanding); end
    checks++;
    if (obs_lk.size() != 1 || obs_lk[0] !== exp_lk[0]) begin
      errors++; $display("FAIL same_lookup got %0d lookups first %h want 1 of %h", obs_lk.size(), obs_lk[0], exp_lk[0]);
    end
    checks++;
    if (obs_beats.size() != 1 || obs_beats[0] !== exp_beats[0]) begin
      errors++; $display("FAIL same_beat got %0d beats first %h want 1 of %h", obs_beats.size(), obs_beats[0], exp_beats[0]);
    end
    rv = 1;
    repeat (5) @(posedge i_clk);
    #1 rv = 0;
    checks++;
    if (outstanding !== 5'd0 || credit_err !== 1'b0) begin
      errors++; $display("FAIL drain_credit got out=%0d err=%b want 0 0", outstanding, credit_err);
    end
    rv = 1;
    @(posedge i_clk); #1 rv = 0;
    drain(1);
    checks++;
    if (outstanding !== 5'd0 || credit_err !== 1'b1) begin
      errors++; $display("FAIL underflow got out=%0d err=%b want 0 1", outstanding, credit_err);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      drive_beat(beat_data(48'h0600_0000_0001, 8'h60, i), 8'hFF, 1'b0, ok);
      if (!ok) begin checks++; errors++; $display("FAIL rst_pre_timeout beat %0d ready never seen", i); end
    end
    s_data = beat_data(48'h0600_0000_0001, 8'h60, 3); s_keep = 8'hFF; s_last = 0; s_valid = 1;
    i_rst = 0;
    #1;
    checks++;
    if ({s_ready, m_valid, m_data, m_keep, m_last, m_user, check_valid, check_mac, check_id} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got rdy=%b mv=%b md=%h cv=%b cm=%h want all 0", s_ready, m_valid, m_data, check_valid, check_mac);
    end
    checks++;
    if ({outstanding, runt_cnt, credit_err} !== '0) begin
      errors++; $display("FAIL rst_mid_status got out=%0d runt=%0d err=%b want 0", outstanding, runt_cnt, credit_err);
    end
    s_valid = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1;
    clear_q(); exp_id = 0;
    send_frame(48'h0700_0000_00AB, 8'h70, 4, 0);
    drain(4);
    checks++;
    if (obs_lk.size() != 1 || obs_lk[0] !== {48'h0700_0000_00AB, 4'd0}) begin
      errors++; $display("FAIL rst_fresh_lookup got %0d lookups first %h want 1 of %h", obs_lk.size(), obs_lk[0], {48'h0700_0000_00AB, 4'd0});
    end
    checks++;
    if (obs_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL rst_fresh_beat_count got %0d want %0d", obs_beats.size(), exp_beats.size());
    end else foreach (exp_beats[i]) begin
      checks++;
      if (obs_beats[i] !== exp_beats[i]) begin errors++; $display("FAIL rst_fresh_beat[%0d] got %h want %h", i, obs_beats[i], exp_beats[i]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    i_rst = 0; s_data = '0; s_keep = '0; s_valid = 0; s_last = 0;
    m_ready = 1; rv = 0; rid = '0; exp_id = '0;
    test_reset();
    test_single();
    test_credit();
    test_runt();
    test_back_to_back();
    test_same_cycle();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
